gift_iter_core: RTL and testbench

GIFT_ITER_CORE -- requirements
Module: gift_iter_core

---
 rtl/gift_iter_core.sv | 169 ++++++++++++++++
 tb/tb_gift_iter_core.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gift_iter_core.sv
// Iterative GIFT-64 / GIFT-128 encryption core: ROUNDS_PER_CYCLE rounds per clock,
// one block in flight, IDLE -> RUN -> DONE handshake FSM.
module gift_iter_core #(
    parameter int BLOCK_BITS       = 128,
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inValid,
    output logic                  outReady,
    input  logic [BLOCK_BITS-1:0] inData,
    input  logic [127:0]          inKey,
    output logic                  outValid,
    input  logic                  inReady,
    output logic [BLOCK_BITS-1:0] outData,
    output logic                  outBusy
);
    localparam int NROUNDS = (BLOCK_BITS == 64) ? 28 : 40;
    localparam int NCYC    = NROUNDS / ROUNDS_PER_CYCLE;
    localparam int CW      = $clog2(NCYC + 1);
    localparam logic [CW-1:0] LAST = CW'(NCYC - 1);

    if (!(BLOCK_BITS == 64 || BLOCK_BITS == 128)) begin : g_bad_block_bits
        $error("gift_iter_core: BLOCK_BITS must be 64 or 128");
    end
    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4)) begin : g_bad_rpc
        $error("gift_iter_core: ROUNDS_PER_CYCLE must be 1, 2 or 4");
    end

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        unique case (x)
            4'h0: y = 4'h1;
            4'h1: y = 4'ha;
            4'h2: y = 4'h4;
            4'h3: y = 4'hc;
            4'h4: y = 4'h6;
            4'h5: y = 4'hf;
            4'h6: y = 4'h3;
            4'h7: y = 4'h9;
            4'h8: y = 4'h2;
            4'h9: y = 4'hd;
            4'ha: y = 4'hb;
            4'hb: y = 4'h7;
            4'hc: y = 4'h5;
            4'hd: y = 4'h0;
            4'he: y = 4'h8;
            default: y = 4'he;
        endcase
        return y;
    endfunction

    // Destination of state bit i under PermBits; only the row stride differs between widths.
    function automatic int perm_pos(input int i);
        return 4 * (i / 16) + (BLOCK_BITS / 4) * ((3 * ((i % 16) / 4) + (i % 4)) % 4) + (i % 4);
    endfunction

    function automatic logic [5:0] rc_next(input logic [5:0] c);
        return {c[4:0], c[5] ^ c[4] ^ 1'b1};
    endfunction

    function automatic logic [127:0] key_next(input logic [127:0] k);
        return {k[17:16], k[31:18], k[11:0], k[15:12], k[127:32]};
    endfunction

    function automatic logic [BLOCK_BITS-1:0] gift_round(
        input logic [BLOCK_BITS-1:0] s,
        input logic [127:0]          k,
        input logic [5:0]            c
    );
        logic [BLOCK_BITS-1:0] sc;
        logic [BLOCK_BITS-1:0] p;
        for (int n = 0; n < BLOCK_BITS / 4; n++) begin
            sc[4*n +: 4] = sbox(s[4*n +: 4]);
        end
        p = '0;
        for (int i = 0; i < BLOCK_BITS; i++) begin
            p[perm_pos(i)] = sc[i];
        end
        for (int i = 0; i < BLOCK_BITS / 4; i++) begin
            if (BLOCK_BITS == 64) begin
                p[4*i+1] ^= k[16+i];
                p[4*i]   ^= k[i];
            end else begin
                p[4*i+2] ^= k[64+i];
                p[4*i+1] ^= k[i];
            end
        end
        for (int b = 0; b < 6; b++) begin
            p[4*b+3] ^= c[b];
        end
        p[BLOCK_BITS-1] ^= 1'b1;
        return p;
    endfunction

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    fsm_t                  fsm_q;
    fsm_t                  fsm_d;
    logic [BLOCK_BITS-1:0] state_q;
    logic [127:0]          key_q;
    logic [5:0]            rc_q;
    logic [CW-1:0]         cnt_q;
    logic [BLOCK_BITS-1:0] s_chain;
    logic [127:0]          k_chain;
    logic [5:0]            c_chain;

    // Constant and key advance between chained rounds exactly as across clock cycles.
    always_comb begin
        s_chain = state_q;
        k_chain = key_q;
        c_chain = rc_q;
        for (int r = 0; r < ROUNDS_PER_CYCLE; r++) begin
            c_chain = rc_next(c_chain);
            s_chain = gift_round(s_chain, k_chain, c_chain);
            k_chain = key_next(k_chain);
        end
    end

    // Handshake: a block transfers on an edge where inValid && outReady; a result transfers
    // on an edge where outValid && inReady. Both sides hold their offer until it transfers.
    always_comb begin
        fsm_d = fsm_q;
        unique case (fsm_q)
            IDLE:    if (inValid) fsm_d = RUN;
            RUN:     if (cnt_q == LAST) fsm_d = DONE;
            DONE:    if (inReady) fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            key_q   <= '0;
            rc_q    <= '0;
            cnt_q   <= '0;
            outData <= '0;
        end else begin
            fsm_q <= fsm_d;
            unique case (fsm_q)
                IDLE: begin
                    if (inValid) begin
                        state_q <= inData;
                        key_q   <= inKey;
                        rc_q    <= '0;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    state_q <= s_chain;
                    key_q   <= k_chain;
                    rc_q    <= c_chain;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        outData <= s_chain;
                    end
                end
                default: ;
            endcase
        end
    end

    assign outReady = (fsm_q == IDLE) && !rst;
    assign outValid = (fsm_q == DONE);
    assign outBusy  = (fsm_q == RUN);

endmodule

// File: tb/tb_gift_iter_core.sv
// Bench for gift_iter_core: a GIFT-128/R=1 instance plus GIFT-64 R=1 and R=4 instances,
// checked against a table-driven GIFT model and known-answer vectors.
module tb_gift_iter_core;
    localparam int NCYC128 = 40;
    localparam logic [3:0] SBOX_T [16] = '{4'h1, 4'ha, 4'h4, 4'hc, 4'h6, 4'hf, 4'h3, 4'h9,
                                           4'h2, 4'hd, 4'hb, 4'h7, 4'h5, 4'h0, 4'h8, 4'he};
    localparam logic [5:0] RC_T [40] = '{
        6'h01, 6'h03, 6'h07, 6'h0f, 6'h1f, 6'h3e, 6'h3d, 6'h3b, 6'h37, 6'h2f,
        6'h1e, 6'h3c, 6'h39, 6'h33, 6'h27, 6'h0e, 6'h1d, 6'h3a, 6'h35, 6'h2b,
        6'h16, 6'h2c, 6'h18, 6'h30, 6'h21, 6'h02, 6'h05, 6'h0b, 6'h17, 6'h2e,
        6'h1c, 6'h38, 6'h31, 6'h23, 6'h06, 6'h0d, 6'h1b, 6'h36, 6'h2d, 6'h1a};

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         in_valid, in_ready, out_ready, out_valid, out_busy;
    logic [127:0] in_data, in_key, out_data;
    logic         d64_valid, d64_ready;
    logic [63:0]  d64_data;
    logic [127:0] d64_key;
    logic         o1_ready, o1_valid, o1_busy, o4_ready, o4_valid, o4_busy;
    logic [63:0]  o1_data, o4_data;

    gift_iter_core #(.BLOCK_BITS(128), .ROUNDS_PER_CYCLE(1)) dut (
        .clk(clk), .rst(rst), .inValid(in_valid), .outReady(out_ready), .inData(in_data),
        .inKey(in_key), .outValid(out_valid), .inReady(in_ready), .outData(out_data),
        .outBusy(out_busy));

    gift_iter_core #(.BLOCK_BITS(64), .ROUNDS_PER_CYCLE(1)) dut64_r1 (
        .clk(clk), .rst(rst), .inValid(d64_valid), .outReady(o1_ready), .inData(d64_data),
        .inKey(d64_key), .outValid(o1_valid), .inReady(d64_ready), .outData(o1_data),
        .outBusy(o1_busy));

    gift_iter_core #(.BLOCK_BITS(64), .ROUNDS_PER_CYCLE(4)) dut64_r4 (
        .clk(clk), .rst(rst), .inValid(d64_valid), .outReady(o4_ready), .inData(d64_data),
        .inKey(d64_key), .outValid(o4_valid), .inReady(d64_ready), .outData(o4_data),
        .outBusy(o4_busy));

    // scoreboard
    int n_checks = 0;
    int n_pass   = 0;
    logic [127:0] exp_q [$];
    logic [127:0] last_ct = '0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // reference model: whole-block GIFT from the round tables and word-level key schedule
    function automatic logic [127:0] gift_ref(input int nb, input logic [127:0] pt,
                                              input logic [127:0] key);
        logic [127:0] s;
        logic [127:0] t;
        logic [15:0]  w [8];
        logic [15:0]  nw [8];
        logic [5:0]   rc;
        int           nr;
        int           dst;
        nr = (nb == 64) ? 28 : 40;
        s = pt;
        for (int j = 0; j < 8; j++) w[j] = key[16*j +: 16];
        for (int r = 0; r < nr; r++) begin
            for (int n = 0; n < nb / 4; n++) s[4*n +: 4] = SBOX_T[s[4*n +: 4]];
            t = '0;
            for (int i = 0; i < nb; i++) begin
                dst = 4 * (i / 16) + (nb / 4) * (((i % 4) - ((i / 4) % 4) + 4) % 4) + (i % 4);
                t[dst] = s[i];
            end
            s = t;
            for (int i = 0; i < nb / 4; i++) begin
                if (nb == 64) begin
                    s[4*i+1] ^= w[1][i];
                    s[4*i]   ^= w[0][i];
                end else begin
                    s[4*i+2] ^= w[4 + i/16][i%16];
                    s[4*i+1] ^= w[i/16][i%16];
                end
            end
            rc = RC_T[r];
            for (int b = 0; b < 6; b++) s[4*b+3] ^= rc[b];
            s[nb-1] ^= 1'b1;
            nw[7] = {w[1][1:0], w[1][15:2]};
            nw[6] = {w[0][11:0], w[0][15:12]};
            for (int j = 0; j < 6; j++) nw[j] = w[j+2];
            for (int j = 0; j < 8; j++) w[j] = nw[j];
        end
        return s;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_block(input string tag, input logic [127:0] pt, input logic [127:0] key,
                             input logic [127:0] exp);
        int lat;
        in_data  = pt;
        in_key   = key;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, "_busy"}, 128'(out_busy), 128'(1));
        check({tag, "_hold_prev"}, out_data, last_ct);
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 128'(lat), 128'(NCYC128));
        check({tag, "_data"}, out_data, exp);
        last_ct   = exp;
        in_ready  = 1'b1;
        tick();
        in_ready  = 1'b0;
        check({tag, "_idle_ready"}, 128'(out_ready), 128'(1));
        check({tag, "_idle_valid"}, 128'(out_valid), 128'(0));
    endtask

    task automatic run64(input string tag, input logic [63:0] pt, input logic [127:0] key,
                         input logic [63:0] exp);
        int lat1;
        int lat4;
        int cyc;
        d64_data  = pt;
        d64_key   = key;
        d64_valid = 1'b1;
        tick();
        d64_valid = 1'b0;
        lat1 = -1;
        lat4 = -1;
        cyc  = 0;
        while ((lat1 < 0 || lat4 < 0) && cyc < 60) begin
            tick();
            cyc++;
            if (lat1 < 0 && o1_valid) lat1 = cyc;
            if (lat4 < 0 && o4_valid) lat4 = cyc;
        end
        check({tag, "_r1_latency"}, 128'(lat1), 128'(28));
        check({tag, "_r4_latency"}, 128'(lat4), 128'(7));
        check({tag, "_r1_data"}, 128'(o1_data), 128'(exp));
        check({tag, "_r4_data"}, 128'(o4_data), 128'(exp));
        d64_ready = 1'b1;
        tick();
        d64_ready = 1'b0;
        check({tag, "_ready"}, 128'({o1_ready, o4_ready}), 128'(2'b11));
    endtask

    initial begin
        logic [127:0] pt;
        logic [127:0] key;
        logic [127:0] exp;
        logic [127:0] m;
        logic         flag;
        int           lat;
        int           last_acc;
        int           n_acc;

        in_valid = 1'b1;
        in_ready = 1'b1;
        in_data  = '0;
        in_key   = '0;
        d64_valid = 1'b0;
        d64_ready = 1'b0;
        d64_data  = '0;
        d64_key   = '0;

        // reset, with inValid/inReady high to show reset wins
        rst = 1'b1;
        repeat (3) tick();
        check("rst_ready", 128'(out_ready), 128'(0));
        check("rst_valid", 128'(out_valid), 128'(0));
        check("rst_busy", 128'(out_busy), 128'(0));
        check("rst_data", out_data, '0);
        rst      = 1'b0;
        in_valid = 1'b0;
        in_ready = 1'b0;
        #1;
        check("rel_ready", 128'({out_ready, o1_ready, o4_ready}), 128'(3'b111));

        // GIFT-64, R=1 and R=4 side by side
        run64("kat64", 64'h0, 128'h0, 64'hf62bc3ef34f775ac);
        for (int i = 0; i < 3; i++) begin
            pt  = rnd128();
            key = rnd128();
            m   = gift_ref(64, {64'h0, pt[63:0]}, key);
            run64("rnd64", pt[63:0], key, m[63:0]);
        end

        // GIFT-128
        run_block("kat128", '0, '0, 128'hcd0bd738388ad3f668b15a36ceb6ff92);
        for (int i = 0; i < 3; i++) begin
            pt  = rnd128();
            key = rnd128();
            run_block("rnd128", pt, key, gift_ref(128, pt, key));
        end

        // backpressure in DONE
        pt  = rnd128();
        key = rnd128();
        exp = gift_ref(128, pt, key);
        in_data = pt; in_key = key; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin tick(); lat++; end
        check("bp_latency", 128'(lat), 128'(NCYC128));
        flag = 1'b1;
        repeat (10) begin
            tick();
            if (!out_valid || out_data !== exp || out_ready) flag = 1'b0;
        end
        check("bp_stable", 128'(flag), 128'(1));
        in_ready = 1'b1;
        tick();
        in_ready = 1'b0;
        check("bp_release_ready", 128'(out_ready), 128'(1));
        check("bp_release_valid", 128'(out_valid), 128'(0));
        check("bp_retain_data", out_data, exp);
        last_ct = exp;

        // input churn while running
        pt  = rnd128();
        key = rnd128();
        exp = gift_ref(128, pt, key);
        in_data = pt; in_key = key; in_valid = 1'b1;
        tick();
        lat = 0;
        while (!out_valid && lat < 100) begin
            in_data  = rnd128();
            in_key   = rnd128();
            in_valid = 1'b1;
            in_ready = 1'($urandom_range(0, 1));
            tick();
            lat++;
        end
        in_valid = 1'b0;
        in_ready = 1'b0;
        check("churn_latency", 128'(lat), 128'(NCYC128));
        check("churn_data", out_data, exp);
        in_ready = 1'b1;
        tick();
        in_ready = 1'b0;
        check("churn_single_accept", 128'({out_ready, out_busy}), 128'(2'b10));
        last_ct = exp;

        // reset in the middle of RUN
        in_data = rnd128(); in_key = rnd128(); in_valid = 1'b1;
        tick();
        repeat (4) tick();
        rst = 1'b1;
        tick();
        in_valid = 1'b0;
        check("midrst_ready_low", 128'(out_ready), 128'(0));
        rst = 1'b0;
        #1;
        check("midrst_ready", 128'(out_ready), 128'(1));
        check("midrst_data", out_data, '0);
        flag = 1'b0;
        repeat (60) begin
            tick();
            if (out_valid || out_busy) flag = 1'b1;
        end
        check("midrst_no_output", 128'(flag), 128'(0));
        last_ct = '0;
        pt  = rnd128();
        key = rnd128();
        run_block("after_rst", pt, key, gift_ref(128, pt, key));

        // back-to-back with inValid and inReady held high
        exp_q.delete();
        in_valid = 1'b1;
        in_ready = 1'b1;
        last_acc = -1;
        n_acc    = 0;
        for (int cyc = 0; cyc < 3 * (NCYC128 + 2) + 4; cyc++) begin
            in_data = rnd128();
            in_key  = rnd128();
            if (out_ready) begin
                exp_q.push_back(gift_ref(128, in_data, in_key));
                if (last_acc >= 0) check("b2b_spacing", 128'(cyc - last_acc), 128'(NCYC128 + 2));
                last_acc = cyc;
                n_acc++;
            end
            tick();
            if (out_valid) begin
                check("b2b_expected", 128'(exp_q.size() != 0), 128'(1));
                if (exp_q.size() != 0) check("b2b_data", out_data, exp_q.pop_front());
            end
        end
        in_valid = 1'b0;
        lat = 0;
        while (exp_q.size() != 0 && lat < 100) begin
            tick();
            lat++;
            if (out_valid) check("b2b_drain_data", out_data, exp_q.pop_front());
        end
        check("b2b_drained", 128'(exp_q.size()), 128'(0));
        check("b2b_accepts", 128'(n_acc), 128'(4));
        in_ready = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
